// File: rtl/gate_stim.sv
// gate_stim: synchronised, debounced x/y operand source for the two-input gate block.
// Build with GATE_STIM_SWEEP_EN defined to add the automatic 00->01->10->11 operand sweep.

module gate_stim_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);
  logic [1:0]  sync;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == 16'(DEB_CYCLES - 1)) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

module gate_stim #(
  parameter int DEB_CYCLES  = 4,
  parameter int STEP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_x,
  input  logic       sw_y,
  input  logic       mode,
  input  logic       hold,
  output logic       x,
  output logic       y,
  output logic       step,
  output logic       wrap,
  output logic [7:0] wraps
);
`ifdef GATE_STIM_SWEEP_EN
  localparam int NUM_CH = 3;
`else
  localparam int NUM_CH = 2;
`endif

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] deb;
  logic [1:0]        xy;
  logic [1:0]        xy_nxt;

`ifdef GATE_STIM_SWEEP_EN
  assign raw = {mode, sw_y, sw_x};
`else
  assign raw = {sw_y, sw_x};
  logic unused;
  assign unused = ^{mode, hold};
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gate_stim_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .deb   (deb[i])
    );
  end

`ifdef GATE_STIM_SWEEP_EN
  localparam logic [1:0] MANUAL = 2'd0;
  localparam logic [1:0] SWEEP  = 2'd1;
  localparam logic [1:0] PAUSE  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  hold_sync;
  logic [15:0] per;
  logic [1:0]  pat;
  logic        wrap_pend;
  logic        deb_mode;
  logic        hold_s;

  assign deb_mode = deb[2];
  assign hold_s   = hold_sync[1];

  // Outputs trail the pattern register by one edge, so a step lands
  // STEP_CYCLES edges after the previous one including the entry 00.
  always_comb begin
    xy_nxt = {deb[0], deb[1]};
    if (state != MANUAL)
      xy_nxt = deb_mode ? pat : xy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= MANUAL;
      hold_sync <= '0;
      per       <= '0;
      pat       <= '0;
      wrap_pend <= 1'b0;
      wrap      <= 1'b0;
      wraps     <= '0;
    end else begin
      hold_sync <= {hold_sync[0], hold};
      wrap      <= 1'b0;
      if (state == MANUAL) begin
        if (deb_mode) begin
          state <= SWEEP;
          pat   <= '0;
          per   <= '0;
        end
      end else if (!deb_mode) begin
        state     <= MANUAL;
        pat       <= '0;
        per       <= '0;
        wrap_pend <= 1'b0;
        wraps     <= '0;
      end else begin
        // The 11->00 pattern step becomes visible on the following edge.
        if (wrap_pend) begin
          wrap      <= 1'b1;
          wraps     <= wraps + 8'd1;
          wrap_pend <= 1'b0;
        end
        if (hold_s) begin
          state <= PAUSE;
        end else begin
          state <= SWEEP;
          if (per == 16'(STEP_CYCLES - 1)) begin
            per <= '0;
            pat <= pat + 2'd1;
            if (pat == 2'b11) wrap_pend <= 1'b1;
          end else begin
            per <= per + 16'd1;
          end
        end
      end
    end
  end
`else
  assign xy_nxt = {deb[0], deb[1]};
  assign wrap   = 1'b0;
  assign wraps  = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xy   <= '0;
      step <= 1'b0;
    end else begin
      xy   <= xy_nxt;
      step <= (xy_nxt != xy);
    end
  end

  assign x = xy[1];
  assign y = xy[0];
endmodule
